spi_reg_writer: RTL and testbench
=================================

// Module: spi_reg_writer
// PURPOSE
//  SPI controller (initiator) that drives write frames into the on-chip SPI register peripheral.
//  Converts a valid/ready register-write request into one 16-bit SPI mode-0 frame:
//  {1'b1 (write), addr[6:0], data[7:0]}, sent MSB first on COPI with nCS framing.
//  Used by test harnesses and by future on-chip sequencers to program the output/PWM enables and duty cycle.
// PARAMETERS
//  CLK_DIV   4   clk cycles per SCLK half-period; legal range 2..255.
//                Must be >=3 when driving the peripheral, which uses a 2-flop input synchroniser.
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  rst_n      in   1  synchronous, active-low reset
//  req_valid  in   1  write request present
//  req_ready  out  1  block can accept a request; high only in IDLE
//  req_addr   in   7  register address
//  req_data   in   8  register write data
//  spi_sclk   out  1  SPI clock, idles low (mode 0)
//  spi_copi   out  1  serial data, controller -> peripheral
//  spi_ncs    out  1  chip select, active low
//  busy       out  1  high from the cycle after accept through the last GAP cycle
//  done       out  1  1-cycle pulse in the last GAP cycle of each frame
//  err        out  1  1-cycle pulse on a rejected request (SPI_REG_WRITER_ADDR_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  Reset values: spi_ncs=1, spi_sclk=0, spi_copi=0, busy=0, done=0, err=0, req_ready=1 (IDLE).
//  FSM states: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
//  - IDLE: accepts a request when req_valid & req_ready are high at a clk edge (cycle T).
//    On accept: latch shift_reg = {1'b1, req_addr, req_data}; go to SHIFT.
//  - SHIFT: starts at T+1.
//    spi_ncs=0; spi_copi=shift_reg[15] from T+1.
//    Each bit = CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
//    COPI changes only in the cycle SCLK falls (never while SCLK is high), giving >= CLK_DIV setup before each rise.
//    A 4-bit bit counter plus a phase counter of width clog2(CLK_DIV) track progress.
//    Exactly 16 rising SCLK edges per frame.
//  - HOLD: after the 16th high phase, SCLK=0 and nCS stays low for CLK_DIV cycles (hold time).
//  - GAP: spi_ncs=1, spi_copi=0 for CLK_DIV cycles (min deselect time).
//    done pulses in the last GAP cycle; req_ready=1 on the following cycle.
//  Timing per frame:
//    nCS low for 33*CLK_DIV cycles.
//    Accept-to-next-accept minimum is 34*CLK_DIV+1 cycles (136+1 at default).
//  Boundaries:
//  - req_valid while busy: ignored, and not queued; the requester must hold it until req_ready.
//  - req_valid in the same cycle as done: not accepted (ready=0); accepted the next cycle if still held.
//  - Request fields are sampled only at accept; later changes have no effect on the frame in flight.
//  - rst_n low mid-frame: at the next edge all outputs take reset values.
//    nCS rises, which aborts the frame; the peripheral discards partial frames. done is not pulsed.
//  - Counters never wrap inside a frame; the bit counter terminates at 15.
// CONFIGURATION
//  SPI_REG_WRITER_ADDR_CHECK_EN defined:
//    a request with req_addr > 7'h04 is consumed in IDLE (req_ready high, as usual).
//    No frame is sent (nCS stays 1) and err pulses for 1 cycle at T+1.
//    req_ready is high again at T+1.
//  SPI_REG_WRITER_ADDR_CHECK_EN undefined:
//    every address is transmitted unchanged; err is constant 0.
// TESTING (CLK_DIV=4 unless noted)
//  1. Reset, then request addr=0x00 data=0xA5.
//     -> Sampling COPI on the 16 SCLK rises yields 0x80A5.
//     -> nCS low for exactly 132 cycles; done pulses once; req_ready returns 137 cycles after accept.
//  2. Loopback to the peripheral: write addr 0x04 = 0x80, then addr 0x02 = 0xFF.
//     -> pwm_duty_cycle=0x80 and en_reg_pwm_7_0=0xFF; all other registers keep their reset value 0x00.
//  3. Hold req_valid high across two requests.
//     -> The 2nd accept occurs exactly 137 cycles after the 1st.
//     -> nCS is high for >= 4 cycles between frames; a request change mid-frame has no effect.
//  4. Assert rst_n=0 for 1 cycle after the 8th SCLK rise.
//     -> spi_ncs=1, spi_sclk=0 on the next edge; no done pulse; peripheral registers unchanged.
//  5. Request addr=0x05 data=0x3C.
//     -> With ADDR_CHECK_EN: err pulses 1 cycle and nCS stays 1.
//     -> Without it: frame 0x853C is sent and err stays 0.
//  6. CLK_DIV=2: repeat scenario 1.
//     -> Frame is 0x80A5; nCS low for 66 cycles; COPI stable during every SCLK high phase.

Source files
------------

// File: rtl/spi_reg_writer.sv
// spi_reg_writer: turns one register-write request into a 16-bit SPI mode-0 write frame.
// Latency: nCS falls and the first COPI bit appears 1 cycle after accept; the frame is
//   33*CLK_DIV cycles of nCS low; accept-to-next-accept is 34*CLK_DIV+1 cycles minimum.
// Backpressure: i_req_valid is only accepted in IDLE (o_req_ready high); it is not queued.
//
// Frame layout (MSB first on COPI): {1'b1 (write), addr[6:0], data[7:0]}.
// SCLK idles low. Each bit is CLK_DIV cycles low then CLK_DIV cycles high, and COPI
// moves only in the cycle SCLK falls, so data is stable for the whole high phase.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_req_valid  write request present
//   o_req_ready  request can be accepted (IDLE only)
//   i_req_addr   7-bit register address
//   i_req_data   8-bit register write data
//   o_spi_sclk   SPI clock (mode 0)
//   o_spi_copi   serial data to the peripheral
//   o_spi_ncs    chip select, active low
//   o_busy       frame in progress (cycle after accept through last GAP cycle)
//   o_done       1-cycle pulse in the last GAP cycle
//   o_err        1-cycle pulse on a rejected request
//
// Build option: define SPI_REG_WRITER_ADDR_CHECK_EN to reject addresses above 7'h04
// (request consumed, no frame sent, o_err pulses). Without it every address is sent
// unchanged and o_err is tied low.

module spi_reg_writer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [6:0] i_req_addr,
  input  logic [7:0] i_req_data,
  output logic       o_spi_sclk,
  output logic       o_spi_copi,
  output logic       o_spi_ncs,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_reg_writer: CLK_DIV must be in 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t          r_state, w_state;
  logic [PW-1:0]   r_phase, w_phase;
  logic [3:0]      r_bit,   w_bit;
  logic [15:0]     r_shift, w_shift;
  logic            r_sclk,  w_sclk;
  logic            r_ncs,   w_ncs;
  logic            w_ph_end;
  logic            w_accept;

  // The shift register is emptied by the 16th fall, so COPI reads 0 in HOLD, GAP and IDLE
  // without a separate output mux.
  assign o_spi_copi  = r_shift[15];
  assign o_spi_sclk  = r_sclk;
  assign o_spi_ncs   = r_ncs;
  assign o_req_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_GAP) && (r_phase == PH_LAST);

  assign w_ph_end = (r_phase == PH_LAST);

`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
  logic r_err;
  logic w_reject;

  assign w_reject = i_req_valid && (r_state == ST_IDLE) && (i_req_addr > 7'h04);
  assign w_accept = i_req_valid && (r_state == ST_IDLE) && !w_reject;
  assign o_err    = r_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_reject;
    end
  end
`else
  assign w_accept = i_req_valid && (r_state == ST_IDLE);
  assign o_err    = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_bit   <= 4'd0;
      r_shift <= 16'h0000;
      r_sclk  <= 1'b0;
      r_ncs   <= 1'b1;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_sclk  <= w_sclk;
      r_ncs   <= w_ncs;
    end
  end

  always_comb begin
    w_state = r_state;
    w_phase = r_phase;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_sclk  = r_sclk;
    w_ncs   = r_ncs;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state = ST_SHIFT;
          w_shift = {1'b1, i_req_addr, i_req_data};
          w_ncs   = 1'b0;
          w_sclk  = 1'b0;
          w_phase = '0;
          w_bit   = 4'd0;
        end
      end

      ST_SHIFT: begin
        if (w_ph_end) begin
          w_phase = '0;
          if (!r_sclk) begin
            w_sclk = 1'b1;
          end else begin
            // Falling edge: next bit goes out now, giving a full low phase of setup.
            w_sclk  = 1'b0;
            w_shift = {r_shift[14:0], 1'b0};
            if (r_bit == 4'd15) begin
              w_state = ST_HOLD;
            end else begin
              w_bit = r_bit + 4'd1;
            end
          end
        end else begin
          w_phase = r_phase + PW'(1);
        end
      end

      ST_HOLD: begin
        if (w_ph_end) begin
          w_phase = '0;
          w_ncs   = 1'b1;
          w_state = ST_GAP;
        end else begin
          w_phase = r_phase + PW'(1);
        end
      end

      ST_GAP: begin
        if (w_ph_end) begin
          w_phase = '0;
          w_state = ST_IDLE;
        end else begin
          w_phase = r_phase + PW'(1);
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_phase = '0;
        w_ncs   = 1'b1;
        w_sclk  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Bench for spi_reg_writer: instance 0 uses CLK_DIV=4, instance 1 uses CLK_DIV=2.
// A monitor decodes each SPI bus (bits captured on SCLK rises) and keeps running
// counters; scenario tasks take baselines and compare deltas against hand values.

module tb_spi_reg_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid [2];
  logic [6:0] req_addr  [2];
  logic [7:0] req_data  [2];
  logic       req_ready [2];
  logic       sclk      [2];
  logic       copi      [2];
  logic       ncs       [2];
  logic       busy      [2];
  logic       done      [2];
  logic       err       [2];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [15:0] cap       [2] = '{16'h0, 16'h0};
  int          rises     [2] = '{0, 0};
  int          stab      [2] = '{0, 0};
  int          ncs_low   [2] = '{0, 0};
  int          done_cnt  [2] = '{0, 0};
  int          done_at   [2] = '{0, 0};
  int          err_cnt   [2] = '{0, 0};
  logic        prev_sclk [2] = '{1'b0, 1'b0};
  logic        prev_copi [2] = '{1'b0, 1'b0};

  spi_reg_writer #(.CLK_DIV(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_addr(req_addr[0]), .i_req_data(req_data[0]),
    .o_spi_sclk(sclk[0]), .o_spi_copi(copi[0]), .o_spi_ncs(ncs[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0])
  );

  spi_reg_writer #(.CLK_DIV(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_addr(req_addr[1]), .i_req_data(req_data[1]),
    .o_spi_sclk(sclk[1]), .o_spi_copi(copi[1]), .o_spi_ncs(ncs[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (sclk[k] === 1'b1 && prev_sclk[k] === 1'b0) begin
        cap[k]   = {cap[k][14:0], copi[k]};
        rises[k] = rises[k] + 1;
      end
      if (sclk[k] === 1'b1 && prev_sclk[k] === 1'b1 && copi[k] !== prev_copi[k])
        stab[k] = stab[k] + 1;
      if (ncs[k] === 1'b0) ncs_low[k] = ncs_low[k] + 1;
      if (done[k] === 1'b1) begin
        done_cnt[k] = done_cnt[k] + 1;
        done_at[k]  = cyc;
      end
      if (err[k] === 1'b1) err_cnt[k] = err_cnt[k] + 1;
      prev_sclk[k] = sclk[k];
      prev_copi[k] = copi[k];
    end
  end

  function automatic int div_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  // Presents a request and returns the edge count at which it is accepted.
  task automatic do_req(input int k, input logic [6:0] a, input logic [7:0] d, output int acc);
    int n;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    req_data[k]  = d;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL accept_timeout[%0d]: req_ready=%b, required 1", k, req_ready[k]);
    end
    acc = cyc + 1;
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  // Waits for req_ready and returns the edge count just before it was seen.
  task automatic wait_ready(input int k, output int rc);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready[k] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL ready_timeout[%0d]: req_ready=%b, required 1", k, req_ready[k]);
    end
    rc = cyc;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_addr[k]  = 7'h00;
      req_data[k]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks += 7;
      if (ncs[k] !== 1'b1)       begin fails++; $display("FAIL reset_ncs[%0d]: got %b, required 1", k, ncs[k]); end
      if (sclk[k] !== 1'b0)      begin fails++; $display("FAIL reset_sclk[%0d]: got %b, required 0", k, sclk[k]); end
      if (copi[k] !== 1'b0)      begin fails++; $display("FAIL reset_copi[%0d]: got %b, required 0", k, copi[k]); end
      if (busy[k] !== 1'b0)      begin fails++; $display("FAIL reset_busy[%0d]: got %b, required 0", k, busy[k]); end
      if (done[k] !== 1'b0)      begin fails++; $display("FAIL reset_done[%0d]: got %b, required 0", k, done[k]); end
      if (err[k] !== 1'b0)       begin fails++; $display("FAIL reset_err[%0d]: got %b, required 0", k, err[k]); end
      if (req_ready[k] !== 1'b1) begin fails++; $display("FAIL reset_ready[%0d]: got %b, required 1", k, req_ready[k]); end
    end
  endtask

  // Single frame addr=0x00 data=0xA5 on instance k; all timings scale with CLK_DIV.
  task automatic test_single_frame(input int k);
    int d, acc, rc, r0, n0, dn0, s0;
    d   = div_of(k);
    r0  = rises[k];
    n0  = ncs_low[k];
    dn0 = done_cnt[k];
    s0  = stab[k];
    do_req(k, 7'h00, 8'hA5, acc);
    checks++;
    if (busy[k] !== 1'b1) begin fails++; $display("FAIL frame_busy[%0d]: got %b, required 1", k, busy[k]); end
    wait_ready(k, rc);
    checks += 7;
    if (cap[k] !== 16'h80A5) begin fails++; $display("FAIL frame_data[%0d]: got %h, required 80a5", k, cap[k]); end
    if (rises[k] - r0 != 16) begin fails++; $display("FAIL frame_rises[%0d]: got %0d, required 16", k, rises[k] - r0); end
    if (ncs_low[k] - n0 != 33 * d) begin fails++; $display("FAIL frame_ncs_low[%0d]: got %0d, required %0d", k, ncs_low[k] - n0, 33 * d); end
    if (done_cnt[k] - dn0 != 1) begin fails++; $display("FAIL frame_done_cnt[%0d]: got %0d, required 1", k, done_cnt[k] - dn0); end
    if (done_at[k] - acc != 34 * d - 1) begin fails++; $display("FAIL frame_done_time[%0d]: got %0d, required %0d", k, done_at[k] - acc, 34 * d - 1); end
    if (rc + 1 - acc != 34 * d + 1) begin fails++; $display("FAIL frame_ready_time[%0d]: got %0d, required %0d", k, rc + 1 - acc, 34 * d + 1); end
    if (stab[k] != s0) begin fails++; $display("FAIL frame_copi_stable[%0d]: got %0d changes, required 0", k, stab[k] - s0); end
  endtask

  task automatic test_reg_writes;
    int acc, rc;
    do_req(0, 7'h04, 8'h80, acc);
    wait_ready(0, rc);
    checks++;
    if (cap[0] !== 16'h8480) begin fails++; $display("FAIL regs_duty: got %h, required 8480", cap[0]); end
    do_req(0, 7'h02, 8'hFF, acc);
    wait_ready(0, rc);
    checks++;
    if (cap[0] !== 16'h82FF) begin fails++; $display("FAIL regs_pwm_en: got %h, required 82ff", cap[0]); end
  endtask

  task automatic test_back_to_back;
    int acc1, acc2, n, gap, rc;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 7'h01;
    req_data[0]  = 8'h11;
    acc1 = cyc + 1;
    @(negedge clk);
    // Mid-frame change while valid stays high: must only affect the second frame.
    req_addr[0] = 7'h02;
    req_data[0] = 8'h22;
    n   = 0;
    gap = 0;
    while (req_ready[0] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (ncs[0] === 1'b1) gap++;
    end
    acc2 = cyc + 1;
    checks += 3;
    if (cap[0] !== 16'h8111) begin fails++; $display("FAIL b2b_first_frame: got %h, required 8111", cap[0]); end
    if (acc2 - acc1 != 137) begin fails++; $display("FAIL b2b_accept_spacing: got %0d, required 137", acc2 - acc1); end
    if (gap < 4) begin fails++; $display("FAIL b2b_ncs_gap: got %0d, required >= 4", gap); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_ready(0, rc);
    checks++;
    if (cap[0] !== 16'h8222) begin fails++; $display("FAIL b2b_second_frame: got %h, required 8222", cap[0]); end
  endtask

  task automatic test_reset_abort;
    int acc, r0, dn0, n0, n;
    r0  = rises[0];
    dn0 = done_cnt[0];
    do_req(0, 7'h03, 8'h5A, acc);
    n = 0;
    while (rises[0] - r0 < 8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks += 5;
    if (ncs[0] !== 1'b1)       begin fails++; $display("FAIL abort_ncs: got %b, required 1", ncs[0]); end
    if (sclk[0] !== 1'b0)      begin fails++; $display("FAIL abort_sclk: got %b, required 0", sclk[0]); end
    if (copi[0] !== 1'b0)      begin fails++; $display("FAIL abort_copi: got %b, required 0", copi[0]); end
    if (req_ready[0] !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b, required 1", req_ready[0]); end
    if (rises[0] - r0 != 8)    begin fails++; $display("FAIL abort_rises: got %0d, required 8", rises[0] - r0); end
    rst_n = 1'b1;
    n0 = ncs_low[0];
    repeat (20) @(negedge clk);
    checks += 2;
    if (done_cnt[0] != dn0) begin fails++; $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt[0] - dn0); end
    if (ncs_low[0] != n0)   begin fails++; $display("FAIL abort_ncs_stays_high: got %0d low cycles, required 0", ncs_low[0] - n0); end
  endtask

  task automatic test_addr_above_range;
    int acc, rc, e0, n0;
    e0 = err_cnt[0];
    n0 = ncs_low[0];
    do_req(0, 7'h05, 8'h3C, acc);
`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
    checks += 2;
    if (err[0] !== 1'b1)       begin fails++; $display("FAIL addr_err_pulse: got %b, required 1", err[0]); end
    if (req_ready[0] !== 1'b1) begin fails++; $display("FAIL addr_ready_back: got %b, required 1", req_ready[0]); end
    repeat (10) @(negedge clk);
    checks += 2;
    if (err_cnt[0] - e0 != 1) begin fails++; $display("FAIL addr_err_count: got %0d, required 1", err_cnt[0] - e0); end
    if (ncs_low[0] != n0)     begin fails++; $display("FAIL addr_no_frame: got %0d low cycles, required 0", ncs_low[0] - n0); end
`else
    wait_ready(0, rc);
    checks += 3;
    if (cap[0] !== 16'h853C)      begin fails++; $display("FAIL addr_frame: got %h, required 853c", cap[0]); end
    if (err_cnt[0] != e0)         begin fails++; $display("FAIL addr_err_quiet: got %0d pulses, required 0", err_cnt[0] - e0); end
    if (ncs_low[0] - n0 != 132)   begin fails++; $display("FAIL addr_ncs_low: got %0d, required 132", ncs_low[0] - n0); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame(0);
    test_reg_writes();
    test_back_to_back();
    test_reset_abort();
    test_addr_above_range();
    test_single_frame(1);
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
